// File: rtl/dlt_sweep_pkg.sv
// Shared types for the CC_DLT bank sweep controller.
// Holds the state enum, LFSR taps and the {sr,g,d} stimulus bundle.
package dlt_sweep_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT_CHK,
    S_DRIVE,
    S_SETTLE,
    S_CHECK,
    S_FINISH
  } state_e;

  // x^16+x^14+x^13+x^11, right-shifting Fibonacci form
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  typedef struct packed {
    logic sr;
    logic g;
    logic d;
  } stim_t;

  function automatic logic [15:0] lfsr_next(
    input logic [15:0] s
  );
    return {^(s & LFSR_TAPS), s[15:1]};
  endfunction

endpackage

// File: rtl/dlt_sweep_ctrl_if.sv
// Host + latch-bank signal bundle for dlt_sweep_ctrl.
// Host: start/busy/done/pass/err_cnt; bank: q in, d/g/sr out.
// DLT_SWEEP_LOG_EN adds first_err_step / first_err_vec.
interface dlt_sweep_ctrl_if #(
  parameter int N_LATCH = 44
);
  logic               start;
  logic [N_LATCH-1:0] q;
  logic               d;
  logic               g;
  logic               sr;
  logic               busy;
  logic               done;
  logic               pass;
  logic [15:0]        err_cnt;
`ifdef DLT_SWEEP_LOG_EN
  logic [15:0]        first_err_step;
  logic [N_LATCH-1:0] first_err_vec;

  modport master (
    input  start, q,
    output d, g, sr, busy, done, pass, err_cnt,
    output first_err_step, first_err_vec
  );
  modport slave (
    output start, q,
    input  d, g, sr, busy, done, pass, err_cnt,
    input  first_err_step, first_err_vec
  );
`else
  modport master (
    input  start, q,
    output d, g, sr, busy, done, pass, err_cnt
  );
  modport slave (
    output start, q,
    input  d, g, sr, busy, done, pass, err_cnt
  );
`endif
endinterface

// File: rtl/dlt_sweep_ctrl_bank_model.sv
// Expected-state model of the whole CC_DLT bank.
// Ports: clk, load_init_i, apply_i, stim_i in; model_o out.
module dlt_bank_model
  import dlt_sweep_pkg::*;
#(
  parameter int               N_LATCH      = 44,
  parameter logic [N_LATCH-1:0] G_INV_MASK   = '0,
  parameter logic [N_LATCH-1:0] SR_INV_MASK  = '0,
  parameter logic [N_LATCH-1:0] SR_VAL_MASK  = '0,
  parameter logic [N_LATCH-1:0] INIT_MASK    = '0,
  parameter logic [N_LATCH-1:0] SR_USED_MASK = '1,
  parameter logic [N_LATCH-1:0] G_CONST_MASK = '0,
  parameter logic [N_LATCH-1:0] G_CONST_VAL  = '0
) (
  input  logic               clk,
  input  logic               load_init_i,
  input  logic               apply_i,
  input  stim_t              stim_i,
  output logic [N_LATCH-1:0] model_o
);

  logic [N_LATCH-1:0] model_q;
  logic [N_LATCH-1:0] model_d;
  logic [N_LATCH-1:0] gsel;
  logic [N_LATCH-1:0] ge;
  logic [N_LATCH-1:0] sra;

  // Tied-SR latches see 0 before the inverter
  always_comb begin
    gsel = (G_CONST_MASK & G_CONST_VAL)
         | (~G_CONST_MASK & {N_LATCH{stim_i.g}});
    ge   = gsel ^ G_INV_MASK;
    sra  = (SR_USED_MASK & {N_LATCH{stim_i.sr}})
         ^ SR_INV_MASK;
    model_d = (sra & SR_VAL_MASK)
            | (~sra & ge & {N_LATCH{stim_i.d}})
            | (~sra & ~ge & model_q);
  end

  // No reset: state survives rst like the real bank
  always_ff @(posedge clk) begin
    if (load_init_i)
      model_q <= INIT_MASK;
    else if (apply_i)
      model_q <= model_d;
  end

  assign model_o = model_q;

endmodule

// File: rtl/dlt_sweep_ctrl.sv
// LFSR-driven sweep and self-check of a CC_DLT latch bank.
// Ports: clk, rst (sync, active high), bus (master modport):
//   start in, q in; d/g/sr, busy, done, pass, err_cnt out.
// Optional macro DLT_SWEEP_LOG_EN adds first-error logging.
module dlt_sweep_ctrl
  import dlt_sweep_pkg::*;
#(
  parameter int                 N_LATCH      = 44,
  parameter logic [N_LATCH-1:0] G_INV_MASK   = 44'h0,
  parameter logic [N_LATCH-1:0] SR_INV_MASK  = 44'h0,
  parameter logic [N_LATCH-1:0] SR_VAL_MASK  = 44'h0,
  parameter logic [N_LATCH-1:0] INIT_MASK    = 44'h0,
  parameter logic [N_LATCH-1:0] SR_USED_MASK =
    (44'hFF_FFFF_FFFF >> 12),
  parameter logic [N_LATCH-1:0] G_CONST_MASK = 44'h0,
  parameter logic [N_LATCH-1:0] G_CONST_VAL  = 44'h0,
  parameter int                 N_STEPS      = 256,
  parameter int                 SETTLE       = 3,
  parameter logic [15:0]        SEED         = 16'hACE1
) (
  input logic             clk,
  input logic             rst,
  dlt_sweep_ctrl_if.master bus
);

  localparam logic [15:0] SETTLE_W = 16'(SETTLE);
  localparam logic [15:0] STEPS_W  = 16'(N_STEPS);

  state_e             state_q, state_d;
  logic [15:0]        step_q, step_d;
  logic [15:0]        cnt_q, cnt_d;
  logic [15:0]        lfsr_q, lfsr_d;
  stim_t              stim_q, stim_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               pass_q, pass_d;
  logic [15:0]        err_q, err_d;
  logic               first_q, first_d;
  logic [N_LATCH-1:0] q_q;
  logic [N_LATCH-1:0] model;
  logic               load_init;
  logic               apply;
  logic               cmp;
  logic               miss;
  logic               start_ok;
  logic [15:0]        step_inc;

  assign start_ok = (state_q == S_IDLE) & bus.start;
  assign miss     = (q_q != model);
  assign step_inc = step_q + 16'd1;

  always_ff @(posedge clk) begin
    q_q <= bus.q;
  end

  dlt_bank_model #(
    .N_LATCH      (N_LATCH),
    .G_INV_MASK   (G_INV_MASK),
    .SR_INV_MASK  (SR_INV_MASK),
    .SR_VAL_MASK  (SR_VAL_MASK),
    .INIT_MASK    (INIT_MASK),
    .SR_USED_MASK (SR_USED_MASK),
    .G_CONST_MASK (G_CONST_MASK),
    .G_CONST_VAL  (G_CONST_VAL)
  ) u_model (
    .clk         (clk),
    .load_init_i (load_init),
    .apply_i     (apply),
    .stim_i      (stim_d),
    .model_o     (model)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      step_q  <= '0;
      cnt_q   <= '0;
      lfsr_q  <= SEED;
      stim_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      first_q <= 1'b1;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      cnt_q   <= cnt_d;
      lfsr_q  <= lfsr_d;
      stim_q  <= stim_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      first_q <= first_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    step_d    = step_q;
    cnt_d     = cnt_q;
    lfsr_d    = lfsr_q;
    stim_d    = stim_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    pass_d    = pass_q;
    err_d     = err_q;
    first_d   = first_q;
    load_init = 1'b0;
    apply     = 1'b0;
    cmp       = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          busy_d  = 1'b1;
          pass_d  = 1'b0;
          err_d   = '0;
          step_d  = '0;
          cnt_d   = '0;
          first_d = 1'b0;
          if (first_q) begin
            load_init = 1'b1;
            stim_d    = '0;
            state_d   = S_INIT_CHK;
          end else begin
            state_d   = S_DRIVE;
          end
        end
      end
      S_INIT_CHK: begin
        if (cnt_q == SETTLE_W) begin
          cmp     = 1'b1;
          state_d = S_DRIVE;
        end else begin
          cnt_d   = cnt_q + 16'd1;
        end
      end
      S_DRIVE: begin
        stim_d  = stim_t'(lfsr_q[2:0]);
        apply   = 1'b1;
        lfsr_d  = lfsr_next(lfsr_q);
        cnt_d   = '0;
        state_d = S_SETTLE;
      end
      S_SETTLE: begin
        if (cnt_q == SETTLE_W - 16'd1)
          state_d = S_CHECK;
        else
          cnt_d   = cnt_q + 16'd1;
      end
      S_CHECK: begin
        cmp    = 1'b1;
        step_d = step_inc;
        if (step_inc == STEPS_W)
          state_d = S_FINISH;
        else
          state_d = S_DRIVE;
      end
      S_FINISH: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        pass_d  = (err_q == 16'd0);
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // One count per failing sample, saturating
    if (cmp && miss && (err_q != 16'hFFFF))
      err_d = err_q + 16'd1;
  end

  assign bus.d       = stim_q.d;
  assign bus.g       = stim_q.g;
  assign bus.sr      = stim_q.sr;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.pass    = pass_q;
  assign bus.err_cnt = err_q;

`ifdef DLT_SWEEP_LOG_EN
  logic [15:0]        fstep_q;
  logic [N_LATCH-1:0] fvec_q;
  logic               logged_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      fstep_q  <= '0;
      fvec_q   <= '0;
      logged_q <= 1'b0;
    end else if (start_ok) begin
      fstep_q  <= '0;
      fvec_q   <= '0;
      logged_q <= 1'b0;
    end else if (cmp && miss && !logged_q) begin
      fstep_q  <= (state_q == S_INIT_CHK) ?
                  16'hFFFF : step_q;
      fvec_q   <= q_q ^ model;
      logged_q <= 1'b1;
    end
  end

  assign bus.first_err_step = fstep_q;
  assign bus.first_err_vec  = fvec_q;
`else
  logic unused_start_ok;
  assign unused_start_ok = start_ok;
`endif

endmodule
